seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Time-multiplexed driver for the Owlboard's 4-digit common-anode seven-segment display. It consumes the 500 Hz scan_clk produced by the clock divider upstream and advances one digit per scan_clk rising edge, all in the 48 MHz clk domain. Input values are double-buffered so a displayed frame never tears. It supports leading-zero blanking and per-digit decimal points.

Parameters:
SEG_ACTIVE_LOW, 1, 1 = seg/dp outputs drive 0 to light a segment; 0 = drive 1 to light.
AN_ACTIVE_LOW, 1, 1 = an outputs drive 0 to enable a digit; 0 = drive 1 to enable.

Ports:
clk  input  1  48 MHz system clock
reset  input  1  asynchronous, active-high reset
scan_clk  input  1  500 Hz divided clock from the divider (a level, synchronous to clk)
value_in  input  16  four hex nibbles; [3:0] is the rightmost digit (digit 0)
dp_in  input  4  decimal-point request per digit; bit k belongs to digit k
blank_lz  input  1  1 = blank leading zero digits
load  input  1  one-cycle strobe that captures value_in/dp_in
an  output  4  digit enables; an[k] drives digit k
seg  output  7  segments, bit order {g,f,e,d,c,b,a}
dp  output  1  decimal point of the active digit
frame_done  output  1  one-clk pulse when digit 3 hands back to digit 0

Behaviour:
- Reset state: an = all digits off, seg = all segments off, dp = off, frame_done = 0. Digit index = 0. scan_prev = 0. Pending registers and display registers = 0.
  - With default parameters this is an = 4'b1111, seg = 7'h7F, dp = 1.
- Edge detect: scan_prev <= scan_clk every clk. advance = scan_clk & ~scan_prev. A high level held for many cycles produces exactly one advance.
- Digit index: 2-bit counter that increments on advance. It wraps from 3 to 0.
- Frame boundary: advance while index == 3.
  - frame_done is 1 for the next clk cycle only.
  - The display registers update at the boundary.
- Load path:
  - load = 1 copies value_in/dp_in into the pending registers.
  - At a frame boundary, display <= pending.
  - If load and the frame boundary occur in the same cycle, display <= value_in/dp_in directly, and pending also takes the new value.
  - Multiple loads within one frame: the last one wins.
- Output latency: an/seg/dp are registered and change exactly 1 clk after the advance. They show the new index using the display registers as they stand after that cycle's update. Digit 0 therefore shows new data on the same cycle as the frame_done pulse.
- Decode: the active nibble goes through a standard hex font.
  - 0 = 7'h3F, 1 = 7'h06, 2 = 7'h5B, 3 = 7'h4F, 4 = 7'h66, 5 = 7'h6D, 6 = 7'h7D, 7 = 7'h07.
  - 8 = 7'h7F, 9 = 7'h6F, A = 7'h77, b = 7'h7C, C = 7'h39, d = 7'h5E, E = 7'h79, F = 7'h71.
  - Values are active-high {g..a}. The output is inverted when SEG_ACTIVE_LOW.
- Leading-zero blanking: with blank_lz = 1, digit k (k = 3..1) is blanked when the display nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit has its anode off, seg off and dp off, even if its dp bit is set.
  - blank_lz is sampled live on every advance, not double-buffered.
- Decimal point: dp is lit when the display dp bit for the active digit is set and the digit is not blanked.
- Exactly one anode is enabled at any time after the first advance, except for blanked slots, where none is enabled. Before the first advance, all anodes are off.
- Reset mid-frame: all state returns immediately to reset values. Scanning resumes at digit 0 on the next advance.

Decomposition:
- Shared include seven_seg_defs.vh holds:
  - the 16 font constants (SEG_0..SEG_F);
  - SEG_BLANK;
  - digit-count localparam NUM_DIGITS = 4.
- Combinational sub-module hex_to_7seg: 4-bit in, 7-bit active-high out, reused by later labs.
- The scanner holds all sequential logic: edge detect, index, pending/display buffers and output registers.

Test Plan:
- Reset check: assert reset mid-run -> an = 4'hF, seg = 7'h7F, dp = 1, frame_done = 0 in the same cycle.
- Basic scan: load 16'h1234, dp_in = 4'b0000, then 8 scan_clk edges.
  - Expected an sequence after the frame boundary: 4'b1110 / seg 7'h66 ('4'), then 4'b1101 / 7'h4F, 4'b1011 / 7'h5B, 4'b0111 / 7'h06.
  - Each change lands 1 clk after the edge; frame_done pulses once per 4 edges.
- Double buffer: load 16'hABCD while digit 1 is active -> digits 2 and 3 still show the old value. A, b, C, d appear only after frame_done.
- Load coincident with boundary: load 16'h00F0 on the exact advance cycle at index 3 -> digit 0 shows '0' (7'h40 inverted) on the very next cycle.
- Blanking: blank_lz = 1, value 16'h0050, dp_in = 4'b1000.
  - Digits 3 and 2 have an = 1 for their slots, and dp stays off.
  - Digit 1 shows '5' (7'h12 active-low); digit 0 shows '0'.
  - Value 16'h0000 lights only digit 0.
- Held scan_clk: hold scan_clk high for 100 clks -> exactly one advance. Apply no edges -> index is frozen.

Source files
------------

// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: hex font, blank pattern,
// digit count and the digit index type. Font values are active-high {g,f,e,d,c,b,a}.
package seven_seg_scanner_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_seg_scanner_hex_to_7seg.sv
// Combinational hex-to-seven-segment font lookup, active-high {g..a}.
import seven_seg_scanner_pkg::*;

module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pure lookup; every nibble value has a glyph.
  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit seven-segment display.
// One digit advance per rising edge of scan_clk (a level in the clk domain).
// Values are double-buffered: load captures into pending, and pending moves
// into the display registers only at the frame boundary (advance from digit 3),
// so a frame never shows a mix of old and new digits.
//
// load protocol: load is a single-cycle strobe with no back-pressure; every
// cycle it is high, value_in/dp_in are captured into pending and the last
// strobe before a frame boundary wins. A strobe on the boundary cycle itself
// goes straight to the display.
import seven_seg_scanner_pkg::*;

module seven_seg_scanner #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  // Output levels meaning "off" for the selected polarities.
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1  : 1'b0;

  logic        scan_prev;
  logic        advance;
  logic        boundary;
  digit_idx_t  idx;
  digit_idx_t  idx_nxt;

  logic [15:0] pend_val;
  logic [3:0]  pend_dp;
  logic [15:0] disp_val;
  logic [3:0]  disp_dp;
  logic [15:0] disp_val_nxt;
  logic [3:0]  disp_dp_nxt;

  logic [3:0]  nibble;
  logic [6:0]  font_seg;
  logic        blanked;
  logic [3:0]  an_on;
  logic [6:0]  seg_on;
  logic        dp_on;

  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q;
  logic        frame_done_q;

  // Rising-edge detect on scan_clk and the boundary condition.
  always_comb begin
    advance  = scan_clk & ~scan_prev;
    boundary = advance & (idx == digit_idx_t'(NUM_DIGITS - 1));
    idx_nxt  = idx + 2'd1;
  end

  // Display contents as they will stand after this cycle; a load on the
  // boundary cycle bypasses pending so the new frame already carries it.
  always_comb begin
    disp_val_nxt = disp_val;
    disp_dp_nxt  = disp_dp;
    if (boundary) begin
      if (load) begin
        disp_val_nxt = value_in;
        disp_dp_nxt  = dp_in;
      end else begin
        disp_val_nxt = pend_val;
        disp_dp_nxt  = pend_dp;
      end
    end
  end

  // Leading-zero blanking for the digit about to be shown; digit 0 is never blanked.
  always_comb begin
    blanked = 1'b0;
    case (idx_nxt)
      2'd1:    blanked = blank_lz & (disp_val_nxt[15:4]  == 12'h000);
      2'd2:    blanked = blank_lz & (disp_val_nxt[15:8]  == 8'h00);
      2'd3:    blanked = blank_lz & (disp_val_nxt[15:12] == 4'h0);
      default: blanked = 1'b0;
    endcase
  end

  // Select the nibble for the next digit and build active-high drive values.
  always_comb begin
    nibble = disp_val_nxt[{idx_nxt, 2'b00} +: 4];
    an_on  = blanked ? 4'b0000 : (4'b0001 << idx_nxt);
    seg_on = blanked ? SEG_BLANK : font_seg;
    dp_on  = ~blanked & disp_dp_nxt[idx_nxt];
  end

  hex_to_7seg u_font (
    .hex (nibble),
    .seg (font_seg)
  );

  // Edge-detect history and digit index counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_prev <= 1'b0;
      idx       <= '0;
    end else begin
      scan_prev <= scan_clk;
      if (advance) begin
        idx <= idx_nxt;
      end
    end
  end

  // Pending buffer: last load in a frame wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_val <= '0;
      pend_dp  <= '0;
    end else if (load) begin
      pend_val <= value_in;
      pend_dp  <= dp_in;
    end
  end

  // Display buffer: only changes at a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      disp_val <= disp_val_nxt;
      disp_dp  <= disp_dp_nxt;
    end
  end

  // Registered digit outputs, refreshed one clk after each advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
    end else if (advance) begin
      an_q  <= AN_ACTIVE_LOW  ? ~an_on  : an_on;
      seg_q <= SEG_ACTIVE_LOW ? ~seg_on : seg_on;
      dp_q  <= SEG_ACTIVE_LOW ? ~dp_on  : dp_on;
    end
  end

  // Single-cycle frame_done pulse following the boundary advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= boundary;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (default active-low polarities).
// A behavioural model tracks digit position, pending/display values and the
// expected pins, computed from the display rules with plain arithmetic.
module tb_seven_seg_scanner;

  logic        clk;
  logic        reset;
  logic        scan_clk;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks;
  int errors;

  seven_seg_scanner dut (
    .clk        (clk),
    .reset      (reset),
    .scan_clk   (scan_clk),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] font [16];
  int         m_idx;
  int unsigned m_pend, m_disp;
  logic [3:0] m_pdp, m_ddp;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_fd;

  initial begin
    font[0]  = 7'h3F; font[1]  = 7'h06; font[2]  = 7'h5B; font[3]  = 7'h4F;
    font[4]  = 7'h66; font[5]  = 7'h6D; font[6]  = 7'h7D; font[7]  = 7'h07;
    font[8]  = 7'h7F; font[9]  = 7'h6F; font[10] = 7'h77; font[11] = 7'h7C;
    font[12] = 7'h39; font[13] = 7'h5E; font[14] = 7'h79; font[15] = 7'h71;
  end

  task automatic model_reset();
    m_idx  = 0;
    m_pend = 0; m_disp = 0;
    m_pdp  = 4'h0; m_ddp = 4'h0;
    e_an   = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
  endtask

  task automatic model_load(input logic [15:0] v, input logic [3:0] d);
    m_pend = v;
    m_pdp  = d;
  endtask

  task automatic model_advance(input bit ld, input logic [15:0] v, input logic [3:0] d,
                               input bit blz);
    int unsigned upper;
    int nib;
    bit blanked;
    if (ld) model_load(v, d);
    e_fd = (m_idx == 3);
    if (e_fd) begin
      m_disp = m_pend;
      m_ddp  = m_pdp;
    end
    m_idx   = (m_idx + 1) % 4;
    upper   = m_disp >> (4 * m_idx);
    nib     = upper % 16;
    blanked = blz && (m_idx != 0) && (upper == 0);
    e_an    = blanked ? 4'hF : (4'hF ^ (4'b0001 << m_idx));
    e_seg   = blanked ? 7'h7F : ~font[nib];
    e_dp    = blanked ? 1'b1 : ~m_ddp[m_idx];
  endtask

  // ---------------- driver tasks ----------------
  // One scan_clk pulse (optionally with a coincident load), then gap low cycles.
  task automatic scan_edge(input string tag, input bit ld, input logic [15:0] v,
                           input logic [3:0] d, input bit blz, input int gap);
    @(negedge clk);
    scan_clk = 1'b1; load = ld; value_in = v; dp_in = d; blank_lz = blz;
    model_advance(ld, v, d, blz);
    @(posedge clk); #1;
    checks++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
      errors++;
      $display("FAIL %s edge idx=%0d: an=%b seg=%h dp=%b fd=%b expected an=%b seg=%h dp=%b fd=%b",
               tag, m_idx, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
    end
    @(negedge clk);
    scan_clk = 1'b0; load = 1'b0; blank_lz = $urandom_range(0, 1);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL %s hold: an=%b seg=%h dp=%b fd=%b expected an=%b seg=%h dp=%b fd=0",
                 tag, an, seg, dp, frame_done, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    load = 1'b1; value_in = v; dp_in = d;
    model_load(v, d);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Advance until the model sits on digit 3 so the next edge is a boundary.
  task automatic go_to_last(input string tag, input bit blz);
    while (m_idx != 3) scan_edge(tag, 1'b0, 16'h0, 4'h0, blz, 1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: an=%b seg=%h dp=%b fd=%b expected an=1111 seg=7f dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    @(negedge clk);
    reset = 1'b0;
    // Loads alone must not light anything before the first advance.
    do_load(16'h8888, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      errors++;
      $display("FAIL pre_advance: an=%b seg=%h dp=%b expected all off", an, seg, dp);
    end
  endtask

  task automatic test_basic_scan();
    do_load(16'h1234, 4'b0000);
    go_to_last("basic_pre", 1'b0);
    for (int i = 0; i < 8; i++) begin
      scan_edge("basic", 1'b0, 16'h0, 4'h0, 1'b0, 3);
      if (i == 0) begin
        checks++;
        if (an !== 4'b1110 || seg !== ~7'h66) begin
          errors++;
          $display("FAIL basic_digit0: an=%b seg=%h expected an=1110 seg=%h", an, seg, ~7'h66);
        end
      end
    end
  endtask

  task automatic test_double_buffer();
    go_to_last("dbuf_pre", 1'b0);
    scan_edge("dbuf", 1'b0, 16'h0, 4'h0, 1'b0, 1);   // digit 0
    scan_edge("dbuf", 1'b0, 16'h0, 4'h0, 1'b0, 1);   // digit 1
    do_load(16'hABCD, 4'b0000);
    scan_edge("dbuf", 1'b0, 16'h0, 4'h0, 1'b0, 1);   // digit 2, still old
    checks++;
    if (seg !== ~7'h5B) begin
      errors++;
      $display("FAIL dbuf_old_digit2: seg=%h expected %h", seg, ~7'h5B);
    end
    scan_edge("dbuf", 1'b0, 16'h0, 4'h0, 1'b0, 1);   // digit 3, still old
    checks++;
    if (seg !== ~7'h06) begin
      errors++;
      $display("FAIL dbuf_old_digit3: seg=%h expected %h", seg, ~7'h06);
    end
    scan_edge("dbuf", 1'b0, 16'h0, 4'h0, 1'b0, 1);   // boundary: new 'd'
    checks++;
    if (seg !== ~7'h5E || frame_done !== 1'b1) begin
      // frame_done already dropped after the hold cycle; recheck only seg
      if (seg !== ~7'h5E) begin
        errors++;
        $display("FAIL dbuf_new_digit0: seg=%h expected %h", seg, ~7'h5E);
      end
    end
    for (int i = 0; i < 3; i++) scan_edge("dbuf_new", 1'b0, 16'h0, 4'h0, 1'b0, 1);
  endtask

  task automatic test_load_on_boundary();
    go_to_last("coinc_pre", 1'b0);
    scan_edge("coinc", 1'b1, 16'h00F0, 4'b0000, 1'b0, 0);
    checks++;
    if (an !== 4'b1110 || seg !== 7'h40) begin
      errors++;
      $display("FAIL coinc_digit0: an=%b seg=%h expected an=1110 seg=40", an, seg);
    end
    for (int i = 0; i < 4; i++) scan_edge("coinc_frame", 1'b0, 16'h0, 4'h0, 1'b0, 1);
  endtask

  task automatic test_blanking();
    do_load(16'h0050, 4'b1000);
    go_to_last("blank_pre", 1'b1);
    for (int i = 0; i < 4; i++) scan_edge("blank", 1'b0, 16'h0, 4'h0, 1'b1, 2);
    do_load(16'h0000, 4'b1111);
    go_to_last("blank0_pre", 1'b1);
    for (int i = 0; i < 4; i++) begin
      scan_edge("blank_zero", 1'b0, 16'h0, 4'h0, 1'b1, 0);
      checks++;
      if (i == 0 ? (an !== 4'b1110 || seg !== 7'h40 || dp !== 1'b0)
                 : (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1)) begin
        errors++;
        $display("FAIL blank_zero_slot%0d: an=%b seg=%h dp=%b", i, an, seg, dp);
      end
    end
  endtask

  task automatic test_held_scan();
    @(negedge clk);
    scan_clk = 1'b1;
    model_advance(1'b0, 16'h0, 4'h0, blank_lz);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== (i == 0 ? e_fd : 1'b0)) begin
        errors++;
        $display("FAIL held_high cyc%0d: an=%b seg=%h dp=%b fd=%b expected an=%b seg=%h dp=%b",
                 i, an, seg, dp, frame_done, e_an, e_seg, e_dp);
      end
    end
    @(negedge clk);
    scan_clk = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      checks++;
      if (an !== e_an || seg !== e_seg || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL frozen cyc%0d: an=%b seg=%h fd=%b expected an=%b seg=%h",
                 i, an, seg, frame_done, e_an, e_seg);
      end
    end
    // Next edge must step by exactly one digit from where the held edge left it.
    scan_edge("after_held", 1'b0, 16'h0, 4'h0, 1'b0, 1);
  endtask

  task automatic test_reset_mid_frame();
    go_to_last("midrst_pre", 1'b0);
    scan_edge("midrst_pre", 1'b0, 16'h0, 4'h0, 1'b0, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: an=%b seg=%h dp=%b fd=%b expected an=1111 seg=7f dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) scan_edge("post_reset", 1'b0, 16'h0, 4'h0, 1'b0, 1);
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 2) == 0) do_load(v, 4'($urandom));
      v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      scan_edge("random", ($urandom_range(0, 3) == 0), v, 4'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; scan_clk = 1'b0; value_in = '0; dp_in = '0; blank_lz = 1'b0; load = 1'b0;
    model_reset();
    test_reset();
    test_basic_scan();
    test_double_buffer();
    test_load_on_boundary();
    test_blanking();
    test_held_scan();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
